// File: rtl/putb.sv
// Bit-run writer: forces a run of Leff bits, from position p downward, to polarity v,
// CHUNK bits per EXEC cycle. Write-side partner of the bit-run counter.
//
// state | meaning
// IDLE  | waiting for start_i; operands captured on acceptance
// EXEC  | writing up to CHUNK bits per cycle, pos/remaining count down
// DONE  | one-cycle done_o pulse, result held on rd_o/cnt_o
module putb #(
    parameter int CHUNK = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] rs0_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] rd_o,
    output logic [5:0]  cnt_o,
    output logic        busy_o,
    output logic        done_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] CHUNK_W = 6'(CHUNK);

    state_t      state_q, state_d;
    logic [5:0]  pos_q;
    logic [5:0]  rem_q;
    logic        pol_q;

    logic [4:0]  p_in;
    logic [5:0]  len_in;
    logic [5:0]  len_sat;
    logic [5:0]  p_plus1;
    logic [5:0]  leff;
    logic [5:0]  w;
    logic [5:0]  shamt;
    logic [31:0] fill;
    logic [31:0] mask;
    logic [31:0] word_next;
    logic        unused_opnd;

    assign unused_opnd = ^{rs1_i[31:5], rs2_i[31:9], rs2_i[7:6]};

    // Leff = min(L saturated to 32, p+1): the run stops at bit 0, never wraps
    always_comb begin
        p_in    = rs1_i[4:0];
        len_in  = rs2_i[5:0];
        len_sat = (len_in > 6'd32) ? 6'd32 : len_in;
        p_plus1 = {1'b0, p_in} + 6'd1;
        leff    = (len_sat < p_plus1) ? len_sat : p_plus1;
    end

    // pos+1-w never goes negative because remaining <= pos+1 throughout the run
    always_comb begin
        w         = (rem_q < CHUNK_W) ? rem_q : CHUNK_W;
        fill      = (w >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        shamt     = pos_q + 6'd1 - w;
        mask      = fill << shamt[4:0];
        word_next = pol_q ? (rd_o | mask) : (rd_o & ~mask);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (leff != 6'd0) ? EXEC : DONE;
                end
            end
            EXEC: begin
                busy_o = 1'b1;
                if (rem_q == w) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_o  <= 32'd0;
            cnt_o <= 6'd0;
            pos_q <= 6'd0;
            rem_q <= 6'd0;
            pol_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rd_o  <= rs0_i;
                        cnt_o <= leff;
                        rem_q <= leff;
                        pos_q <= {1'b0, p_in};
                        pol_q <= rs2_i[8];
                    end
                end
                EXEC: begin
                    rd_o  <= word_next;
                    pos_q <= pos_q - w;
                    rem_q <= rem_q - w;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_putb.sv
// Self-checking bench for putb: vector table plus random ops through a scoreboard,
// with hand sequences for busy-start, mid-run reset and back-to-back operation.
module tb_putb;
    localparam int CHUNK = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] rs0_i, rs1_i, rs2_i;
    logic [31:0] rd_o;
    logic [5:0]  cnt_o;
    logic        busy_o, done_o;

    putb #(.CHUNK(CHUNK)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start_i(start_i),
        .rs0_i  (rs0_i),
        .rs1_i  (rs1_i),
        .rs2_i  (rs2_i),
        .rd_o   (rd_o),
        .cnt_o  (cnt_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rs0;
        logic [4:0]  p;
        logic [5:0]  len;
        logic        v;
        logic [31:0] rd;
        logic [5:0]  cnt;
        int          n;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic [5:0]  cnt;
        int          n;
    } exp_t;

    vec_t tbl[10];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // independent reference: bit-by-bit membership test of the clipped run
    task automatic model(input logic [31:0] rs0, input logic [4:0] p, input logic [5:0] len,
                         input logic v, output logic [31:0] rd, output logic [5:0] cnt,
                         output int n);
        int leff;
        leff = (int'(len) > 32) ? 32 : int'(len);
        if (leff > int'(p) + 1) leff = int'(p) + 1;
        rd = rs0;
        for (int i = 0; i < 32; i++) begin
            if (i <= int'(p) && i > int'(p) - leff) rd[i] = v;
        end
        cnt = 6'(leff);
        n   = (leff + CHUNK - 1) / CHUNK;
    endtask

    task automatic drive_ops(input logic [31:0] rs0, input logic [4:0] p,
                             input logic [5:0] len, input logic v);
        rs0_i = rs0;
        rs1_i = ($urandom() & 32'hFFFF_FFE0) | {27'd0, p};
        rs2_i = ($urandom() & ~32'h0000_013F) | {23'd0, v, 2'b00, len};
    endtask

    task automatic run_op(input vec_t t, input bit poke, input string nm);
        exp_t e;
        int   c;
        bit   got;
        @(negedge clk_i);
        drive_ops(t.rs0, t.p, t.len, t.v);
        start_i = 1'b1;
        e.rd = t.rd; e.cnt = t.cnt; e.n = t.n;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1 start_i = 1'b0;
        if (poke) drive_ops($urandom(), 5'($urandom()), 6'($urandom()), 1'($urandom()));
        c = 0;
        got = 1'b0;
        while (!got && c < 60) begin
            @(negedge clk_i);
            if (done_o) begin
                got = 1'b1;
                e = sb_q.pop_front();
                chk({nm, " latency"}, 32'(c), 32'(e.n));
                chk({nm, " rd"}, rd_o, e.rd);
                chk({nm, " cnt"}, 32'(cnt_o), 32'(e.cnt));
                chk({nm, " busy_done"}, 32'(busy_o), 32'd1);
            end else begin
                if (!busy_o) chk({nm, " busy_exec"}, 32'(busy_o), 32'd1);
                c++;
            end
            if (poke) begin
                start_i = 1'b1;
                drive_ops($urandom(), 5'($urandom()), 6'($urandom()), 1'($urandom()));
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_done required=done", nm);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(negedge clk_i);
        chk({nm, " done_pulse"}, 32'(done_o), 32'd0);
        chk({nm, " idle_busy"}, 32'(busy_o), 32'd0);
        chk({nm, " rd_hold"}, rd_o, t.rd);
        chk({nm, " cnt_hold"}, 32'(cnt_o), 32'(t.cnt));
    endtask

    initial begin
        vec_t t;
        bit   saw_done;
        int   cyc;
        int   done_t[$];

        tbl[0] = '{32'h0000_0000, 5'd31, 6'd12, 1'b1, 32'hFFF0_0000, 6'd12, 2};
        tbl[1] = '{32'hFFFF_FFFF, 5'd7,  6'd40, 1'b0, 32'hFFFF_FF00, 6'd8,  1};
        tbl[2] = '{32'h1234_5678, 5'd10, 6'd0,  1'b1, 32'h1234_5678, 6'd0,  0};
        tbl[3] = '{32'h0000_0000, 5'd3,  6'd2,  1'b1, 32'h0000_000C, 6'd2,  1};
        tbl[4] = '{32'h0000_0000, 5'd31, 6'd32, 1'b1, 32'hFFFF_FFFF, 6'd32, 4};
        tbl[5] = '{32'hA5A5_A5A5, 5'd0,  6'd1,  1'b0, 32'hA5A5_A5A4, 6'd1,  1};
        tbl[6] = '{32'h0000_0000, 5'd4,  6'd63, 1'b1, 32'h0000_001F, 6'd5,  1};
        tbl[7] = '{32'hFFFF_FFFF, 5'd20, 6'd9,  1'b0, 32'hFFE0_0FFF, 6'd9,  2};
        tbl[8] = '{32'h0000_0000, 5'd31, 6'd33, 1'b1, 32'hFFFF_FFFF, 6'd32, 4};
        tbl[9] = '{32'h0F0F_0F0F, 5'd15, 6'd8,  1'b1, 32'h0F0F_FF0F, 6'd8,  1};

        rst_ni  = 1'b0;
        start_i = 1'b0;
        rs0_i   = 32'hDEAD_BEEF;
        rs1_i   = 32'd0;
        rs2_i   = 32'd0;
        repeat (2) @(negedge clk_i);
        chk("reset rd", rd_o, 32'd0);
        chk("reset cnt", 32'(cnt_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i], i == 0 || i == 4, $sformatf("vec%0d", i));
        end

        // reset in the second EXEC cycle of a 4-chunk op
        @(negedge clk_i);
        drive_ops(32'h0000_0000, 5'd31, 6'd32, 1'b1);
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid busy_exec", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid rd", rd_o, 32'd0);
        chk("rst_mid cnt", 32'(cnt_o), 32'd0);
        chk("rst_mid busy", 32'(busy_o), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            if (done_o) saw_done = 1'b1;
        end
        rst_ni = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            if (done_o) saw_done = 1'b1;
        end
        chk("rst_mid no_done", 32'(saw_done), 32'd0);
        run_op(tbl[4], 1'b0, "after_rst");

        // start held high: one op per N+2 cycles
        @(negedge clk_i);
        drive_ops(32'h0000_0000, 5'd15, 6'd16, 1'b1);
        start_i = 1'b1;
        for (cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk_i);
            if (done_o) begin
                done_t.push_back(cyc);
                chk("b2b rd", rd_o, 32'h0000_FFFF);
            end
        end
        start_i = 1'b0;
        chk("b2b count_ge2", 32'(done_t.size() >= 2), 32'd1);
        for (int i = 1; i < done_t.size(); i++) begin
            chk("b2b period", 32'(done_t[i] - done_t[i-1]), 32'd4);
        end
        repeat (8) @(negedge clk_i);

        for (int i = 0; i < 20; i++) begin
            t.rs0 = $urandom();
            t.p   = 5'($urandom_range(0, 31));
            t.len = 6'($urandom_range(0, 63));
            t.v   = 1'($urandom_range(0, 1));
            model(t.rs0, t.p, t.len, t.v, t.rd, t.cnt, t.n);
            run_op(t, i[0], $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/putb.md
Name: putb

Overview:
- Multi-cycle custom-instruction unit that writes a run of identical bits into a register word.
- It is the write-side counterpart of the bit-run counter.
- Given a destination word, a start bit position, a run length and a polarity, it sets bits p, p-1, … downward to the polarity value, processing CHUNK bits per EXEC cycle.
- Sits beside the counter in the coprocessor datapath; the top level drives start_i and consumes rd_o/done_o.

Parameters:
CHUNK, 8, bits written per EXEC cycle; legal values 1, 2, 4, 8, 16, 32.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  reset, asynchronous assert, active-low
start_i  input  1  start request, sampled only in IDLE
rs0_i  input  32  destination word to be modified
rs1_i  input  32  start bit position p = rs1_i[4:0]; bits [31:5] ignored
rs2_i  input  32  run length L = rs2_i[5:0]; polarity v = rs2_i[8]; other bits ignored
rd_o  output  32  result word, registered; valid while done_o=1, held until next accepted start
cnt_o  output  6  effective number of bits written (Leff), registered alongside rd_o
busy_o  output  1  1 while in EXEC or DONE
done_o  output  1  one-cycle pulse, 1 only in DONE

Behaviour:
- Clock is clk_i; reset is rst_ni, asynchronous and active-low.
- Reset values: state=IDLE, rd_o=0, cnt_o=0, busy_o=0, done_o=0. Internal position and remaining-count registers are cleared to 0.
- States: IDLE, EXEC, DONE (2-bit encoding).
- Leff = min(L, 32, p+1). The run is clipped at bit 0 and never wraps to bit 31. L in 33..63 saturates to 32 before clipping.
- N = ceil(Leff/CHUNK).
- IDLE with start_i=1 at edge k:
  - Capture rs0_i into the working word rd_o. Capture p and v. Capture remaining=Leff and cnt_o=Leff.
  - Go to EXEC if Leff>0, else go directly to DONE with rd_o=rs0_i.
- IDLE with start_i=0: hold all state.
- EXEC, each edge:
  - w = min(CHUNK, remaining).
  - Bits pos .. pos-w+1 of the working word are forced to v; all other bits are unchanged.
  - pos decrements by w; remaining decrements by w.
  - If remaining reaches 0, go to DONE; else stay in EXEC.
- pos arithmetic is 6-bit. The pos underflow after writing bit 0 is don't-care because remaining is 0 at that point.
- DONE: done_o=1 for exactly one cycle, then unconditionally go to IDLE. rd_o and cnt_o hold their values.
- Latency: with start accepted at edge k, done_o is high between edges k+N and k+N+1. For Leff=0 this is k..k+1.
- start_i while busy (EXEC/DONE) is ignored. No queuing; the operand inputs may change freely after acceptance.
- start_i=1 in the DONE cycle is ignored. A new start is accepted only once the unit is back in IDLE, on the next edge.
- Back-to-back operation: start held high continuously yields one operation per N+2 cycles.
- Operands are captured at acceptance only. Changes to rs0_i/rs1_i/rs2_i during EXEC have no effect.
- Reset asserted mid-EXEC or in DONE: immediately return to IDLE with all outputs at reset values. No done pulse occurs.
- Bits outside the run are bit-exact copies of rs0_i.

Test Plan:
- rs0=0x00000000, p=31, L=12, v=1, CHUNK=8 -> N=2, rd_o=0xFFF00000, cnt_o=12, done_o high exactly one cycle after edge k+2, busy_o high k..k+3.
- rs0=0xFFFFFFFF, p=7, L=40, v=0 -> L saturates to 32, Leff=8, rd_o=0xFFFFFF00, cnt_o=8, done after edge k+1.
- rs0=0x12345678, L=0 -> no EXEC cycle, done after edge k, rd_o=0x12345678, cnt_o=0.
- rs0=0x00000000, p=3, L=2, v=1 -> rd_o=0x0000000C, cnt_o=2. Repeat with p=31, L=32 -> rd_o=0xFFFFFFFF, N=4.
- Pulse start_i again during EXEC and during DONE with different operands -> ignored, first result unchanged, exactly one done pulse.
- Assert rst_ni=0 during the second EXEC cycle of a p=31, L=32 op -> rd_o=0, cnt_o=0, busy_o=0, no done_o. A start after release completes normally.
